// File: rtl/otp_ctrl_pkg.sv
// Shared types and constants for the OTP shadow controller.
package otp_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD_RD,
    LOAD_REC,
    IDLE,
    PGM,
    PGM_REC,
    VFY_RD,
    DONE
  } otp_state_e;

  localparam int LOCK_BIT = 0;
  localparam int REC_CYC  = 1;

endpackage

// File: rtl/otp_cyc_timer.sv
// Loadable down-counter that times OTP read, program and recovery phases.
module otp_cyc_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/otp_shadow_ctrl.sv
// OTP controller: boot-time shadow load, host shadow reads, and timed
// program pulses with read-back verify and a lock bit.
module otp_shadow_ctrl
  import otp_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4,
  parameter int RD_WAIT   = 4,
  parameter int PGM_CYC   = 200
) (
  input  logic                        xtal_clk,
  input  logic                        por_rst,
  input  logic [ADDR_W-1:0]           hif_raddr,
  output logic [DATA_W-1:0]           hif_rdata,
  input  logic                        hif_pgm_req,
  input  logic                        hif_reload_req,
  input  logic [ADDR_W-1:0]           hif_addr,
  input  logic [DATA_W-1:0]           hif_wdata,
  output logic                        hif_busy,
  output logic                        hif_ack,
  output logic                        pgm_err,
  output logic                        load_done,
  output logic [DATA_W*NUM_WORDS-1:0] shadow_flat,
  output logic [ADDR_W-1:0]           o_otp_addr,
  output logic                        o_otp_ce,
  output logic                        o_otp_rd,
  output logic                        o_otp_pgm,
  output logic [DATA_W-1:0]           o_otp_d,
  input  logic [DATA_W-1:0]           i_otp_q
);

  localparam int MAX_CYC = (RD_WAIT > PGM_CYC) ? RD_WAIT : PGM_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = $clog2(NUM_WORDS);

  localparam logic [TW-1:0]     RD_LOAD   = TW'(RD_WAIT - 1);
  localparam logic [TW-1:0]     PGM_LOAD  = TW'(PGM_CYC - 1);
  localparam logic [TW-1:0]     REC_LOAD  = TW'(REC_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   NUM_WORDS_X = (ADDR_W + 1)'(NUM_WORDS);

  otp_state_e        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] pgm_addr;
  logic [DATA_W-1:0] pgm_data;
  logic [DATA_W-1:0] shadow [NUM_WORDS];
  logic              tmr_load;
  logic [TW-1:0]     tmr_value;
  logic              tmr_zero;

  otp_cyc_timer #(.W(TW)) u_timer (
    .clk   (xtal_clk),
    .rst   (por_rst),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_flat
    assign shadow_flat[i*DATA_W +: DATA_W] = shadow[i];
  end

  // A phase is entered with its strobe low; the first cycle raises the strobe
  // and loads the timer, the zero flag then marks the last strobe cycle.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      LOAD_RD: begin
        if (!o_otp_rd) begin
          tmr_load  = 1'b1;
          tmr_value = RD_LOAD;
        end else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = REC_LOAD;
        end
      end
      LOAD_REC: begin
        if (tmr_zero && idx != LAST_IDX) begin
          tmr_load  = 1'b1;
          tmr_value = RD_LOAD;
        end
      end
      PGM: begin
        if (!o_otp_pgm) begin
          tmr_load  = 1'b1;
          tmr_value = PGM_LOAD;
        end else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = REC_LOAD;
        end
      end
      PGM_REC: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = RD_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Host handshake: hif_pgm_req / hif_reload_req are single-cycle pulses taken
  // only in IDLE (dropped otherwise); a program request ends with exactly one
  // hif_ack pulse carrying pgm_err, a reload ends when load_done rises.
  always_ff @(posedge xtal_clk or posedge por_rst) begin
    if (por_rst) begin
      state      <= LOAD_RD;
      idx        <= '0;
      pgm_addr   <= '0;
      pgm_data   <= '0;
      hif_busy   <= 1'b0;
      hif_ack    <= 1'b0;
      pgm_err    <= 1'b0;
      load_done  <= 1'b0;
      o_otp_addr <= '0;
      o_otp_ce   <= 1'b0;
      o_otp_rd   <= 1'b0;
      o_otp_pgm  <= 1'b0;
      o_otp_d    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
    end else begin
      hif_ack <= 1'b0;
      case (state)
        LOAD_RD: begin
          if (!o_otp_rd) begin
            o_otp_ce   <= 1'b1;
            o_otp_rd   <= 1'b1;
            o_otp_addr <= idx;
            hif_busy   <= 1'b1;
          end else if (tmr_zero) begin
            shadow[idx[IW-1:0]] <= i_otp_q;
            o_otp_ce <= 1'b0;
            o_otp_rd <= 1'b0;
            state    <= LOAD_REC;
          end
        end
        LOAD_REC: begin
          if (tmr_zero) begin
            if (idx == LAST_IDX) begin
              load_done <= 1'b1;
              hif_busy  <= 1'b0;
              state     <= IDLE;
            end else begin
              idx        <= idx + 1'b1;
              o_otp_ce   <= 1'b1;
              o_otp_rd   <= 1'b1;
              o_otp_addr <= idx + 1'b1;
              state      <= LOAD_RD;
            end
          end
        end
        IDLE: begin
          if (hif_reload_req) begin
            load_done <= 1'b0;
            idx       <= '0;
            hif_busy  <= 1'b1;
            state     <= LOAD_RD;
          end else if (hif_pgm_req) begin
            if (({1'b0, hif_addr} >= NUM_WORDS_X) ||
                shadow[LAST_IDX[IW-1:0]][LOCK_BIT]) begin
              hif_ack <= 1'b1;
              pgm_err <= 1'b1;
            end else begin
              pgm_addr <= hif_addr;
              pgm_data <= hif_wdata;
              hif_busy <= 1'b1;
              state    <= PGM;
            end
          end
        end
        PGM: begin
          if (!o_otp_pgm) begin
            o_otp_ce   <= 1'b1;
            o_otp_pgm  <= 1'b1;
            o_otp_addr <= pgm_addr;
            o_otp_d    <= pgm_data;
          end else if (tmr_zero) begin
            o_otp_ce  <= 1'b0;
            o_otp_pgm <= 1'b0;
            o_otp_d   <= '0;
            state     <= PGM_REC;
          end
        end
        PGM_REC: begin
          if (tmr_zero) begin
            o_otp_ce   <= 1'b1;
            o_otp_rd   <= 1'b1;
            o_otp_addr <= pgm_addr;
            state      <= VFY_RD;
          end
        end
        VFY_RD: begin
          if (tmr_zero) begin
            shadow[pgm_addr[IW-1:0]] <= i_otp_q;
            pgm_err  <= (i_otp_q != (shadow[pgm_addr[IW-1:0]] | pgm_data));
            o_otp_ce <= 1'b0;
            o_otp_rd <= 1'b0;
            hif_ack  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          hif_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge xtal_clk or posedge por_rst) begin
    if (por_rst) begin
      hif_rdata <= '0;
    end else if ({1'b0, hif_raddr} < NUM_WORDS_X) begin
      hif_rdata <= shadow[hif_raddr[IW-1:0]];
    end else begin
      hif_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_otp_shadow_ctrl.sv
// Self-checking bench for otp_shadow_ctrl against a behavioural OTP and shadow model.
module tb_otp_shadow_ctrl;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int RW = 3;
  localparam int PC = 10;

  logic              xtal_clk = 1'b0;
  logic              por_rst  = 1'b1;
  logic [AW-1:0]     hif_raddr = '0;
  logic [DW-1:0]     hif_rdata;
  logic              hif_pgm_req = 1'b0;
  logic              hif_reload_req = 1'b0;
  logic [AW-1:0]     hif_addr = '0;
  logic [DW-1:0]     hif_wdata = '0;
  logic              hif_busy;
  logic              hif_ack;
  logic              pgm_err;
  logic              load_done;
  logic [DW*NW-1:0]  shadow_flat;
  logic [AW-1:0]     o_otp_addr;
  logic              o_otp_ce;
  logic              o_otp_rd;
  logic              o_otp_pgm;
  logic [DW-1:0]     o_otp_d;
  logic [DW-1:0]     i_otp_q;

  int n_checks = 0;
  int n_fail   = 0;
  int pgm_hi   = 0;
  int ce_hi    = 0;
  int ack_cnt  = 0;

  // OTP contents: factory image plus bits burned by program pulses.
  bit [DW-1:0] base_mem [8];
  bit [DW-1:0] burn_mem [8];
  bit          ignore_pgm [8];
  logic [DW-1:0] sh [NW];

  always #5 xtal_clk = ~xtal_clk;

  otp_shadow_ctrl #(
    .DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW), .RD_WAIT(RW), .PGM_CYC(PC)
  ) dut (
    .xtal_clk       (xtal_clk),
    .por_rst        (por_rst),
    .hif_raddr      (hif_raddr),
    .hif_rdata      (hif_rdata),
    .hif_pgm_req    (hif_pgm_req),
    .hif_reload_req (hif_reload_req),
    .hif_addr       (hif_addr),
    .hif_wdata      (hif_wdata),
    .hif_busy       (hif_busy),
    .hif_ack        (hif_ack),
    .pgm_err        (pgm_err),
    .load_done      (load_done),
    .shadow_flat    (shadow_flat),
    .o_otp_addr     (o_otp_addr),
    .o_otp_ce       (o_otp_ce),
    .o_otp_rd       (o_otp_rd),
    .o_otp_pgm      (o_otp_pgm),
    .o_otp_d        (o_otp_d),
    .i_otp_q        (i_otp_q)
  );

  assign i_otp_q = (o_otp_ce && o_otp_rd) ?
                   (base_mem[o_otp_addr] | burn_mem[o_otp_addr]) : 8'hA5;

  always @(negedge xtal_clk) begin
    if (o_otp_pgm) pgm_hi++;
    if (o_otp_ce) ce_hi++;
    if (hif_ack) ack_cnt++;
    if (o_otp_pgm && o_otp_ce && !ignore_pgm[o_otp_addr])
      burn_mem[o_otp_addr] = burn_mem[o_otp_addr] | o_otp_d;
  end

  function automatic logic [DW-1:0] eff(input int a);
    return base_mem[a] | burn_mem[a];
  endfunction

  function automatic logic [DW*NW-1:0] flat_model();
    logic [DW*NW-1:0] f;
    for (int i = 0; i < NW; i++) f[i*DW +: DW] = sh[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge xtal_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic boot();
    int p0, t;
    por_rst = 1'b1;
    hif_pgm_req = 1'b0;
    hif_reload_req = 1'b0;
    hif_raddr = '0;
    repeat (2) tick();
    check("rst_load_done", load_done, 0);
    check("rst_busy", hif_busy, 0);
    check("rst_ack", hif_ack, 0);
    check("rst_err", pgm_err, 0);
    check("rst_ce", o_otp_ce, 0);
    check("rst_rd", o_otp_rd, 0);
    check("rst_pgm", o_otp_pgm, 0);
    check("rst_d", o_otp_d, 0);
    check("rst_addr", o_otp_addr, 0);
    check("rst_flat", shadow_flat, 0);
    check("rst_rdata", hif_rdata, 0);
    p0 = pgm_hi;
    por_rst = 1'b0;
    tick();
    t = 0;
    while (!load_done && t < 100) begin
      tick();
      t++;
    end
    check("load_time", t, NW * (RW + 1));
    for (int i = 0; i < NW; i++) sh[i] = eff(i);
    check("load_flat", shadow_flat, flat_model());
    check("load_no_pgm", pgm_hi - p0, 0);
    check("load_idle_busy", hif_busy, 0);
  endtask

  task automatic do_pgm(input int a, input logic [DW-1:0] d);
    bit accept;
    logic [DW-1:0] exp_new;
    logic exp_err;
    int lat, p0, c0;
    accept  = (a < NW) && !sh[NW-1][0];
    exp_new = '0;
    exp_err = 1'b1;
    if (accept) begin
      exp_new = ignore_pgm[a] ? eff(a) : (eff(a) | d);
      exp_err = (exp_new != (sh[a] | d));
    end
    p0 = pgm_hi;
    c0 = ce_hi;
    hif_addr = AW'(a);
    hif_wdata = d;
    hif_pgm_req = 1'b1;
    tick();
    hif_pgm_req = 1'b0;
    check("pgm_busy", hif_busy, accept);
    lat = 1;
    while (!hif_ack && lat < 100) begin
      tick();
      lat++;
    end
    check("pgm_latency", lat, accept ? (PC + RW + 3) : 1);
    check("pgm_err", pgm_err, exp_err);
    check("pgm_pulse", pgm_hi - p0, accept ? PC : 0);
    if (!accept) check("pgm_reject_ce", ce_hi - c0, 0);
    if (accept) sh[a] = exp_new;
    check("pgm_flat", shadow_flat, flat_model());
    tick();
    check("ack_one_cycle", hif_ack, 0);
    check("err_hold", pgm_err, exp_err);
  endtask

  task automatic do_reload(input bit with_pgm, input bit busy_pgm);
    int a0, p0, t;
    a0 = ack_cnt;
    p0 = pgm_hi;
    hif_reload_req = 1'b1;
    hif_pgm_req = with_pgm;
    hif_addr = AW'(1);
    hif_wdata = 8'hF0;
    tick();
    hif_reload_req = 1'b0;
    hif_pgm_req = 1'b0;
    check("reload_clear", load_done, 0);
    check("reload_busy", hif_busy, 1);
    if (busy_pgm) begin
      tick();
      hif_pgm_req = 1'b1;
      tick();
      hif_pgm_req = 1'b0;
    end
    t = 0;
    while (!load_done && t < 100) begin
      tick();
      t++;
    end
    check("reload_done", load_done, 1);
    for (int i = 0; i < NW; i++) sh[i] = eff(i);
    check("reload_flat", shadow_flat, flat_model());
    repeat (20) tick();
    check("reload_no_ack", ack_cnt - a0, 0);
    check("reload_no_pgm", pgm_hi - p0, 0);
  endtask

  task automatic read_chk(input int r);
    hif_raddr = AW'(r);
    tick();
    check("rdata", hif_rdata, (r < NW) ? sh[r] : 0);
  endtask

  initial begin
    int a, t;
    logic [DW-1:0] d;
    base_mem[0] = 8'h11;
    base_mem[1] = 8'h22;
    base_mem[2] = 8'h33;
    base_mem[3] = 8'h00;

    boot();
    check("boot_image", shadow_flat, 32'h00332211);

    do_pgm(0, 8'h44);
    check("word0_prog", shadow_flat[7:0], 8'h55);
    read_chk(3);
    read_chk(0);

    ignore_pgm[2] = 1'b1;
    do_pgm(2, 8'h80);
    check("word2_kept", shadow_flat[23:16], 8'h33);
    ignore_pgm[2] = 1'b0;

    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, 2);
      d = DW'($urandom_range(0, 255));
      ignore_pgm[a] = ($urandom_range(0, 3) == 0);
      do_pgm(a, d);
      ignore_pgm[a] = 1'b0;
    end
    for (int k = 0; k < 6; k++) read_chk($urandom_range(0, 7));

    base_mem[3] = 8'h01;
    do_reload(1'b0, 1'b0);
    do_pgm(0, 8'h0F);
    base_mem[3] = 8'h00;
    do_reload(1'b0, 1'b0);
    do_pgm(5, 8'h0F);
    do_pgm(1, DW'($urandom_range(0, 255)));

    do_reload(1'b1, 1'b1);

    hif_addr = AW'(1);
    hif_wdata = DW'($urandom_range(1, 255));
    hif_pgm_req = 1'b1;
    tick();
    hif_pgm_req = 1'b0;
    t = 0;
    while (!o_otp_pgm && t < 5) begin
      tick();
      t++;
    end
    check("mid_pgm_started", o_otp_pgm, 1);
    repeat (4) tick();
    #2;
    por_rst = 1'b1;
    #1;
    check("async_pgm_drop", o_otp_pgm, 0);
    check("async_ce_drop", o_otp_ce, 0);
    check("async_flat", shadow_flat, 0);
    check("async_load_done", load_done, 0);
    boot();
    check("post_rst_rdata", hif_rdata, sh[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
